cmul_seq: RTL and testbench



---
 rtl/cmul_seq_if.sv | 28 ++
 rtl/cmul_seq.sv | 116 +++++++++++
 tb/tb_cmul_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cmul_seq_if.sv
// cmul_seq_if: operand/result handshake bundle for the sequential complex multiplier.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: a, b, res are packed {re, im} signed Q1.(PART_LEN-1); conj selects a*conj(b).
interface cmul_seq_if #(
   parameter int PART_LEN = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2*PART_LEN-1:0]   a;
   logic [2*PART_LEN-1:0]   b;
   logic                    conj;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*PART_LEN-1:0]   res;

   // master drives operands and consumes results
   modport master (
      output in_valid, a, b, conj, out_ready,
      input  in_ready, out_valid, res
   );

   // slave is the multiplier itself
   modport slave (
      input  in_valid, a, b, conj, out_ready,
      output in_ready, out_valid, res
   );
endinterface

// File: rtl/cmul_seq.sv
// cmul_seq: complex multiply a*b or a*conj(b) using one shared signed multiplier over 4 cycles.
// Latency: accept at edge k -> out_valid after edge k+4; one operation in flight, 6-cycle minimum interval.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, input never buffered.
// Ports: clk, rst (sync, active-high); bus (cmul_seq_if.slave) carries both handshakes, a, b, conj, res.
module cmul_seq #(
   parameter int PART_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   cmul_seq_if.slave   bus
);
   localparam int PW = PART_LEN;
   localparam int AW = 2*PART_LEN + 1;

   // saturation bounds expressed at accumulator width
   localparam logic signed [AW-1:0] SMAX = {{(AW-PW+1){1'b0}}, {(PW-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = {{(AW-PW+1){1'b1}}, {(PW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

   state_t state, state_nxt;

   logic signed [PW-1:0]  ar, ai, br;
   logic signed [PW:0]    bi_eff;      // one extra bit so negating the most negative value is exact
   logic signed [AW-1:0]  acc_re, acc_im;
   logic [2*PW-1:0]       res_q;

   logic signed [PW:0]    bi_in;
   logic                  accept;

   logic signed [PW-1:0]  mul_x;
   logic signed [PW:0]    mul_y;
   logic signed [AW-1:0]  prod;
   logic signed [AW-1:0]  acc_im_fin;

   assign accept = (state == IDLE) && bus.in_valid;
   assign bi_in  = {bus.b[PW-1], bus.b[PW-1:0]};

   // shift back to Q1.(PW-1) (floor) and clamp into the part range
   function automatic logic [PW-1:0] scale_sat(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] s;
      s = v >>> (PW-1);
      if (s > SMAX)      s = SMAX;
      else if (s < SMIN) s = SMIN;
      return s[PW-1:0];
   endfunction

   // operand select for the single shared multiplier
   always_comb begin
      mul_x = ar;
      mul_y = {br[PW-1], br};
      case (state)
         P1:      begin mul_x = ai; mul_y = bi_eff;          end
         P2:      begin mul_x = ar; mul_y = bi_eff;          end
         P3:      begin mul_x = ai; mul_y = {br[PW-1], br};  end
         default: begin mul_x = ar; mul_y = {br[PW-1], br};  end
      endcase
   end

   // PW x (PW+1) signed product fits AW bits exactly
   assign prod       = mul_x * mul_y;
   assign acc_im_fin = acc_im + prod;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)        state_nxt = P0;
         P0:                         state_nxt = P1;
         P1:                         state_nxt = P2;
         P2:                         state_nxt = P3;
         P3:                         state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ar     <= '0;
         ai     <= '0;
         br     <= '0;
         bi_eff <= '0;
         acc_re <= '0;
         acc_im <= '0;
         res_q  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  ar     <= bus.a[2*PW-1:PW];
                  ai     <= bus.a[PW-1:0];
                  br     <= bus.b[2*PW-1:PW];
                  bi_eff <= bus.conj ? -bi_in : bi_in;
                  acc_re <= '0;
                  acc_im <= '0;
               end
            end
            P0: acc_re <= acc_re + prod;
            P1: acc_re <= acc_re - prod;
            P2: acc_im <= acc_im + prod;
            P3: begin
               acc_im <= acc_im_fin;
               res_q  <= {scale_sat(acc_re), scale_sat(acc_im_fin)};
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.res       = res_q;

endmodule

// File: tb/tb_cmul_seq.sv
module tb_cmul_seq;
   localparam int P = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmul_seq_if #(.PART_LEN(P)) bus ();

   cmul_seq #(.PART_LEN(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // reference: direct complex product, floor shift, clamp
   function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      int ar, ai, br, bi, re, im;
      logic [7:0] r8, i8;
      ar = int'($signed(av[15:8]));
      ai = int'($signed(av[7:0]));
      br = int'($signed(bv[15:8]));
      bi = int'($signed(bv[7:0]));
      if (cv) bi = -bi;
      re = (ar*br - ai*bi) >>> 7;
      im = (ar*bi + ai*br) >>> 7;
      if (re > 127) re = 127; else if (re < -128) re = -128;
      if (im > 127) im = 127; else if (im < -128) im = -128;
      r8 = re[7:0];
      i8 = im[7:0];
      return {r8, i8};
   endfunction

   // present operands at a negedge, returns at the negedge after acceptance
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic [15:0] expv);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", bus.in_ready, 1);
      bus.a        = av;
      bus.b        = bv;
      bus.conj     = cv;
      bus.in_valid = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      bus.in_valid = 1'b0;
      // scramble inputs: the DUT must work from its own copies
      bus.a    = 16'($urandom);
      bus.b    = 16'($urandom);
      bus.conj = 1'($urandom);
   endtask

   // wait for out_valid, check latency and scoreboard result
   task automatic collect(input string tag, output logic [15:0] got);
      int lat;
      logic [15:0] e;
      lat = 1;
      chk({tag, "_busy"}, bus.in_ready, 0);
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat - 1, 4);
      got = bus.res;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, "_res"}, bus.res, e);
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] expv);
      logic [15:0] got;
      bus.out_ready = 1'b1;
      send(av, bv, cv, expv);
      collect(tag, got);
      @(negedge clk);
      chk({tag, "_ovdrop"}, bus.out_valid, 0);
      chk({tag, "_rdyback"}, bus.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] held, got, ra, rb;
      logic rc;
      int seen;

      // reset with in_valid high: must not accept
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 16'h4000;
      bus.b         = 16'h0040;
      bus.conj      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_res", bus.res, 16'h0000);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_no_accept", bus.in_ready, 1);

      // directed functional cases
      run_op("basic",     16'h4000, 16'h0040, 1'b0, 16'h0020);
      run_op("conj1",     16'h4040, 16'h4040, 1'b1, 16'h4000);
      run_op("conj0",     16'h4040, 16'h4040, 1'b0, 16'h0040);
      run_op("sat_im",    16'h8080, 16'h8080, 1'b0, 16'h007F);
      run_op("sat_re",    16'h8080, 16'h8080, 1'b1, 16'h7F00);
      run_op("floor_neg", 16'hC000, 16'h0100, 1'b0, 16'hFF00);
      run_op("sat_neg",   16'h8000, 16'h7F00, 1'b1, 16'h8100);

      // backpressure: hold in DONE for 10 cycles with in_valid pulses
      bus.out_ready = 1'b0;
      send(16'h4040, 16'h4040, 1'b1, 16'h4000);
      collect("bp", held);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a        = 16'($urandom);
         @(negedge clk);
         chk("bp_res_stable", bus.res, held);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", bus.out_valid, 0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen++;
      end
      chk("bp_single", seen, 0);

      // reset while in P2
      send(16'h4040, 16'h4040, 1'b0, 16'h0040);
      void'(exp_q.pop_back());
      @(negedge clk);              // P1
      @(negedge clk);              // P2
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_idle", bus.in_ready, 1);
      chk("midrst_ov", bus.out_valid, 0);
      chk("midrst_res", bus.res, 16'h0000);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      chk("midrst_no_out", seen, 0);
      run_op("after_rst", 16'h7F00, 16'h7F00, 1'b0, 16'h7E00);

      // random operands against the reference model
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         run_op("rand", ra, rb, rc, model(ra, rb, rc));
      end

      chk("sb_empty", exp_q.size(), 0);
      got = 16'h0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
